fifo_async_wptr_ctrl: RTL and testbench

Write-side pointer and status controller for the asynchronous FIFO, parametrised in address width, with a programmable almost-full threshold, a registered fill level and a sticky overflow flag. It sits entirely in the write clock domain. It consumes the read pointer after it has passed the two-flop synchroniser, and it drives the Gray write pointer to the synchroniser feeding the read side. It also drives the binary write address to the dual-port RAM.

---
 rtl/fifo_async_wptr_ctrl.sv | 131 +++++++++++++
 tb/tb_fifo_async_wptr_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fifo_async_wptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_async_wptr_ctrl
//
// Write-side pointer and status controller of an asynchronous FIFO. Lives
// entirely in the write clock domain. It takes the Gray read pointer after it
// has been synchronised into WCLK. It produces the binary and Gray write
// pointers, the RAM write address, and registered fill status.
//
// Parameters
//   ADDR_WIDTH  RAM address bits (2..16); DEPTH = 2**ADDR_WIDTH,
//               pointer width P = ADDR_WIDTH+1
//   AF_THRESH   fill level at which ALMOST_FULL asserts (1..DEPTH)
//
// Ports
//   WCLK         in   write clock, rising edge
//   NRST         in   synchronous active-low reset
//   W_EN         in   write request for this cycle
//   OVF_CLR      in   clears the sticky OVERFLOW flag
//   RPTR_G_SYNC  in   P  Gray read pointer, already synchronised to WCLK
//   WADDR        out  ADDR_WIDTH  RAM write address (low bits of WPTR_B)
//   WPTR_B       out  P  binary write pointer
//   WPTR_G       out  P  Gray write pointer, to the read-side synchroniser
//   FULL         out  FIFO full
//   ALMOST_FULL  out  fill level >= AF_THRESH
//   WLEVEL       out  P  fill level 0..DEPTH as seen from the write side
//   OVERFLOW     out  sticky: a write was attempted while FULL
//
// The RAM write strobe is W_EN & ~FULL, applied at the current WADDR.
// ---------------------------------------------------------------------------
module fifo_async_wptr_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  WCLK,
    input  logic                  NRST,
    input  logic                  W_EN,
    input  logic                  OVF_CLR,
    input  logic [ADDR_WIDTH:0]   RPTR_G_SYNC,
    output logic [ADDR_WIDTH-1:0] WADDR,
    output logic [ADDR_WIDTH:0]   WPTR_B,
    output logic [ADDR_WIDTH:0]   WPTR_G,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   WLEVEL,
    output logic                  OVERFLOW
);

    localparam int P     = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [P-1:0] AF_THRESH_P = P'(AF_THRESH);

    // Elaboration-time parameter sanity checks.
    if (ADDR_WIDTH < 2 || ADDR_WIDTH > 16) begin : g_bad_aw
        $error("fifo_async_wptr_ctrl: ADDR_WIDTH out of range 2..16");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_async_wptr_ctrl: AF_THRESH out of range 1..DEPTH");
    end

    function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
        logic [P-1:0] b;
        b[P-1] = g[P-1];
        for (int i = P - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [P-1:0] wptr_b_q, wptr_b_d;
    logic [P-1:0] wptr_g_q, wptr_g_d;
    logic [P-1:0] level_q,  level_d;
    logic         full_q,   full_d;
    logic         af_q,     af_d;
    logic         ovf_q,    ovf_d;

    logic [P-1:0] rbin;
    logic         accept;

    always_comb begin
        rbin   = gray2bin(RPTR_G_SYNC);
        accept = W_EN & ~full_q;

        // Pointers wrap naturally modulo 2**P.
        wptr_b_d = wptr_b_q + {{(P-1){1'b0}}, accept};
        wptr_g_d = (wptr_b_d >> 1) ^ wptr_b_d;

        // Modular difference never exceeds DEPTH because writes stop at full.
        level_d = wptr_b_d - rbin;

        // Full: pointers one lap apart, i.e. MSBs differ, address bits equal.
        full_d = (wptr_b_d[P-1] != rbin[P-1]) &&
                 (wptr_b_d[P-2:0] == rbin[P-2:0]);
        af_d   = (level_d >= AF_THRESH_P);

        // A set event (write while full) takes priority over a clear.
        if (W_EN && full_q) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge WCLK) begin
        if (!NRST) begin
            wptr_b_q <= '0;
            wptr_g_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_b_q <= wptr_b_d;
            wptr_g_q <= wptr_g_d;
            level_q  <= level_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign WPTR_B      = wptr_b_q;
    assign WPTR_G      = wptr_g_q;
    assign WADDR       = wptr_b_q[P-2:0];
    assign WLEVEL      = level_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = af_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_fifo_async_wptr_ctrl.sv
// Testbench for fifo_async_wptr_ctrl (ADDR_WIDTH=3, AF_THRESH=6).
module tb_fifo_async_wptr_ctrl;

    localparam int AW = 3;

    logic          WCLK = 1'b0;
    logic          NRST;
    logic          W_EN;
    logic          OVF_CLR;
    logic [AW:0]   RPTR_G_SYNC;
    logic [AW-1:0] WADDR;
    logic [AW:0]   WPTR_B;
    logic [AW:0]   WPTR_G;
    logic          FULL;
    logic          ALMOST_FULL;
    logic [AW:0]   WLEVEL;
    logic          OVERFLOW;

    fifo_async_wptr_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(6)) dut (
        .WCLK(WCLK), .NRST(NRST), .W_EN(W_EN), .OVF_CLR(OVF_CLR),
        .RPTR_G_SYNC(RPTR_G_SYNC), .WADDR(WADDR), .WPTR_B(WPTR_B),
        .WPTR_G(WPTR_G), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
        .WLEVEL(WLEVEL), .OVERFLOW(OVERFLOW)
    );

    always #5 WCLK = ~WCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0d got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    typedef struct {
        bit nrst; bit we; bit clr; int rp;
        int wp; int lvl; bit full; bit af; bit ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit nrst, input bit we, input bit clr, input int rp,
                       input int wp, input int lvl, input bit full, input bit af,
                       input bit ovf);
        vec_t v;
        v = '{nrst, we, clr, rp, wp, lvl, full, af, ovf};
        tbl.push_back(v);
    endtask

    task automatic check_outputs(input int idx, input int wp, input int lvl,
                                 input bit full, input bit af, input bit ovf);
        chk("WPTR_B", idx, int'(WPTR_B), wp & 15);
        chk("WPTR_G", idx, int'(WPTR_G), gray(wp & 15));
        chk("WADDR", idx, int'(WADDR), wp & 7);
        chk("WLEVEL", idx, int'(WLEVEL), lvl);
        chk("FULL", idx, int'(FULL), int'(full));
        chk("ALMOST_FULL", idx, int'(ALMOST_FULL), int'(af));
        chk("OVERFLOW", idx, int'(OVERFLOW), int'(ovf));
    endtask

    initial begin
        int wtot, rtot, rd1, rd2, rs, lvl, wraps, full_obs;
        bit we, clr, accept, m_full, m_ovf;
        logic [AW:0] prev_b, prev_g;

        NRST = 1'b0; W_EN = 1'b0; OVF_CLR = 1'b0; RPTR_G_SYNC = '0;

        // ---------------- directed table ----------------
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);                  // reset, write discarded
        for (int i = 1; i <= 8; i++)                     // fill to full
            add(1, 1, 0, 0, i, i, i == 8, i >= 6, 0);
        add(1, 1, 0, 0, 8, 8, 1, 1, 1);                  // write while full
        add(1, 1, 0, 0, 8, 8, 1, 1, 1);
        add(1, 1, 1, 0, 8, 8, 1, 1, 1);                  // set beats clear
        add(1, 0, 1, 0, 8, 8, 1, 1, 0);                  // clear alone
        add(1, 0, 0, 3, 8, 5, 0, 0, 0);                  // read ptr -> 3
        add(1, 0, 0, 4, 8, 4, 0, 0, 0);
        add(1, 1, 0, 5, 9, 4, 0, 0, 0);                  // simultaneous r/w
        add(1, 1, 0, 5, 10, 5, 0, 0, 0);
        add(1, 1, 0, 5, 11, 6, 0, 1, 0);
        add(1, 1, 0, 5, 12, 7, 0, 1, 0);
        add(1, 1, 0, 5, 13, 8, 1, 1, 0);
        add(1, 1, 0, 5, 13, 8, 1, 1, 1);
        add(1, 0, 0, 6, 13, 7, 0, 1, 1);                 // level 7, overflow set
        add(0, 1, 0, 6, 0, 0, 0, 0, 0);                  // reset mid-operation
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            NRST = tbl[i].nrst; W_EN = tbl[i].we; OVF_CLR = tbl[i].clr;
            RPTR_G_SYNC = 4'(gray(tbl[i].rp));
            @(posedge WCLK); #1;
            check_outputs(i, tbl[i].wp, tbl[i].lvl, tbl[i].full, tbl[i].af, tbl[i].ovf);
        end

        // ---------------- randomized laps vs reference model ----------------
        wtot = 0; rtot = 0; rd1 = 0; rd2 = 0;
        m_full = 0; m_ovf = 0; wraps = 0; full_obs = 0;
        NRST = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            we  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 15) == 0);
            rs  = rd2;                                   // read pointer lagging 2 cycles
            W_EN = we; OVF_CLR = clr;
            RPTR_G_SYNC = 4'(gray(rs & 15));
            prev_b = WPTR_B; prev_g = WPTR_G;

            accept = we && !m_full;
            if (accept) wtot++;
            if (we && m_full) m_ovf = 1;
            else if (clr)     m_ovf = 0;
            lvl    = wtot - rs;
            m_full = (lvl == 8);

            @(posedge WCLK); #1;
            check_outputs(1000 + cyc, wtot, lvl % 16, m_full, lvl >= 6, m_ovf);
            if (accept)
                chk("gray_1bit", 1000 + cyc, $countones(prev_g ^ WPTR_G), 1);
            if (prev_b == 4'd15 && WPTR_B == 4'd0) wraps++;
            if (FULL) full_obs++;
            if (int'(WLEVEL) < wtot - rtot)
                chk("level_pessimistic", 1000 + cyc, int'(WLEVEL), wtot - rtot);

            if (rtot < wtot && $urandom_range(0, 1) == 1) rtot++;
            rd2 = rd1;
            rd1 = rtot;
        end
        chk("wrap_15_to_0_seen", 0, int'(wraps >= 3), 1);
        chk("full_seen", 0, int'(full_obs > 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
